// File: rtl/decode_hazard_unit_pkg.sv
// Shared types and constants for the decode-stage hazard unit.
// Entries describe one in-flight instruction's destination register.
package decode_hazard_unit_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam logic [ADDR_WIDTH-1:0] PC_REG_NUM = 4'd15;
    localparam int NUM_STAGES = 3;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_EX      = 2'd1,
        FWD_MEM     = 2'd2,
        FWD_WB      = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] dest;
        logic                  is_load;
    } hazard_entry_t;

    // The PC is read from the fetch path, so it never matches an in-flight writer.
    function automatic logic entry_match(hazard_entry_t entry, logic [ADDR_WIDTH-1:0] addr);
        return entry.valid && (entry.dest == addr) && (addr != PC_REG_NUM);
    endfunction

endpackage

// File: rtl/decode_hazard_unit_if.sv
// Decoder <-> hazard unit signal bundle, plus read-only views of the tracked
// EX/MEM/WB entries. All signals are level-qualified per cycle; there is no handshake.
interface decode_hazard_unit_if;

    logic                                          instr_valid_i;
    logic [decode_hazard_unit_pkg::ADDR_WIDTH-1:0] reg_addr_1_i;
    logic [decode_hazard_unit_pkg::ADDR_WIDTH-1:0] reg_addr_2_i;
    logic [decode_hazard_unit_pkg::ADDR_WIDTH-1:0] reg_dest_addr_i;
    logic                                          use_1_i;
    logic                                          use_2_i;
    logic                                          writes_reg_i;
    logic                                          is_load_i;
    logic                                          flush_i;
    logic                                          hold_i;
    logic                                          stall_o;
    decode_hazard_unit_pkg::fwd_sel_t              fwd_sel_1_o;
    decode_hazard_unit_pkg::fwd_sel_t              fwd_sel_2_o;
    decode_hazard_unit_pkg::hazard_entry_t         ex_entry;
    decode_hazard_unit_pkg::hazard_entry_t         mem_entry;
    decode_hazard_unit_pkg::hazard_entry_t         wb_entry;

    modport master (
        output instr_valid_i, reg_addr_1_i, reg_addr_2_i, reg_dest_addr_i,
        output use_1_i, use_2_i, writes_reg_i, is_load_i, flush_i, hold_i,
        input  stall_o, fwd_sel_1_o, fwd_sel_2_o, ex_entry, mem_entry, wb_entry
    );

    modport slave (
        input  instr_valid_i, reg_addr_1_i, reg_addr_2_i, reg_dest_addr_i,
        input  use_1_i, use_2_i, writes_reg_i, is_load_i, flush_i, hold_i,
        output stall_o, fwd_sel_1_o, fwd_sel_2_o, ex_entry, mem_entry, wb_entry
    );

endinterface

// File: rtl/decode_hazard_unit_operand_fwd_select.sv
// Forwarding select for one source operand against the EX/MEM/WB entries.
// Index 0 is EX (youngest); scanning oldest-first lets the youngest match win.
module decode_hazard_unit_operand_fwd_select
    import decode_hazard_unit_pkg::*;
(
    input  logic                  instr_valid,
    input  logic                  use_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  hazard_entry_t         entries [NUM_STAGES],
    output fwd_sel_t              sel,
    output logic                  load_use
);

    logic src_is_load;

    always_comb begin
        sel         = FWD_REGFILE;
        src_is_load = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (instr_valid && use_op && entry_match(entries[i], addr)) begin
                sel         = fwd_sel_t'(2'(i + 1));
                src_is_load = entries[i].is_load;
            end
        end
        // Load data only exists at the end of MEM, so a load still in EX cannot be forwarded.
        load_use = (sel == FWD_EX) && src_is_load;
    end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard unit: tracks in-flight destinations in a 3-deep shift
// pipeline and produces per-operand forwarding selects and a load-use stall.
module decode_hazard_unit
    import decode_hazard_unit_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    decode_hazard_unit_if.slave  dec
);

    hazard_entry_t pipe_q [NUM_STAGES];
    hazard_entry_t ex_next;
    fwd_sel_t      sel_1;
    fwd_sel_t      sel_2;
    logic          load_use_1;
    logic          load_use_2;
    logic          stall;

    decode_hazard_unit_operand_fwd_select u_sel_1 (
        .instr_valid (dec.instr_valid_i),
        .use_op      (dec.use_1_i),
        .addr        (dec.reg_addr_1_i),
        .entries     (pipe_q),
        .sel         (sel_1),
        .load_use    (load_use_1)
    );

    decode_hazard_unit_operand_fwd_select u_sel_2 (
        .instr_valid (dec.instr_valid_i),
        .use_op      (dec.use_2_i),
        .addr        (dec.reg_addr_2_i),
        .entries     (pipe_q),
        .sel         (sel_2),
        .load_use    (load_use_2)
    );

    // A flushed instruction is discarded anyway, so it must not stall the front end.
    assign stall = (load_use_1 || load_use_2) && !dec.flush_i && !reset_i;

    always_comb begin
        ex_next.valid   = dec.instr_valid_i && dec.writes_reg_i && !stall && !dec.flush_i;
        ex_next.dest    = dec.reg_dest_addr_i;
        ex_next.is_load = dec.is_load_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (!dec.hold_i) begin
            pipe_q[2] <= pipe_q[1];
            pipe_q[1] <= pipe_q[0];
            pipe_q[0] <= ex_next;
        end
    end

    // Tracked state is undefined until the reset edge, so outputs are forced idle.
    assign dec.stall_o     = stall;
    assign dec.fwd_sel_1_o = reset_i ? FWD_REGFILE : sel_1;
    assign dec.fwd_sel_2_o = reset_i ? FWD_REGFILE : sel_2;
    assign dec.ex_entry    = pipe_q[0];
    assign dec.mem_entry   = pipe_q[1];
    assign dec.wb_entry    = pipe_q[2];

endmodule

// File: doc/decode_hazard_unit.md
Name: decode_hazard_unit

Overview:
- Sits in the decode stage, directly downstream of the register-address decoder; consumes its two source addresses and destination address per instruction.
- Tracks destination registers of in-flight instructions in EX, MEM and WB in a 3-entry shift pipeline.
- Per source operand, produces forwarding selects and a load-use stall for the fetch/decode pipeline registers.

Parameters:
- ADDR_WIDTH, 4, register address width (r0-r15).
- PC_REG_NUM, 15, PC register number; never forwarded, never stalls.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- instr_valid_i  in  1  decode slot holds a real instruction
- reg_addr_1_i  in  ADDR_WIDTH  source operand 1 address
- reg_addr_2_i  in  ADDR_WIDTH  source operand 2 address
- reg_dest_addr_i  in  ADDR_WIDTH  destination address
- use_1_i  in  1  operand 1 address meaningful (decoder drives X otherwise)
- use_2_i  in  1  operand 2 address meaningful
- writes_reg_i  in  1  instruction writes reg_dest_addr_i
- is_load_i  in  1  result comes from memory (available end of MEM)
- flush_i  in  1  branch taken; kill decode-slot instruction
- hold_i  in  1  downstream memory stall; freeze whole pipeline
- stall_o  out  1  hold fetch/decode, inject bubble into EX
- fwd_sel_1_o  out  2  operand 1 source: 0 regfile, 1 EX, 2 MEM, 3 WB
- fwd_sel_2_o  out  2  operand 2 source, same encoding

Behaviour:
- State: for each of EX, MEM, WB, one entry {valid, dest[ADDR_WIDTH-1:0], is_load}.
- Reset: all entries valid=0. stall_o=0, fwd_sel_1_o=0, fwd_sel_2_o=0 for the whole reset cycle, regardless of inputs.
- Match condition for operand n: use_n_i & instr_valid_i & entry.valid & entry.dest==reg_addr_n_i & reg_addr_n_i!=PC_REG_NUM.
- fwd_sel_n_o is combinational, with priority EX > MEM > WB (youngest wins); 0 when nothing matches.
- Load-use hazard: any operand matches the EX entry and EX.is_load=1. Then stall_o=1 for exactly one cycle; the load then sits in MEM and the next cycle selects 2.
- stall_o is suppressed when flush_i=1 or reset_i=1.
- Capture into EX: new entry = {instr_valid_i & writes_reg_i & ~stall_o & ~flush_i, reg_dest_addr_i, is_load_i}. A bubble (valid=0) is inserted when stalled or flushed.
- Advance on each rising edge when hold_i=0: EX->MEM, MEM->WB, WB is dropped, then EX is captured.
- hold_i=1: all entries frozen; outputs still computed combinationally from the frozen state. hold_i has priority over flush_i for state update; flush is re-presented by the upstream logic.
- Destination PC_REG_NUM is tracked like any register, but can never match because source PC is excluded.
- Operand 1 and operand 2 naming the same register both get the same select.
- writes_reg_i=0 (e.g. CMP, store): no tracked destination.
- Multi-register push/pop: SP tracked as a single destination, decoded upstream into reg_dest_addr_i=13.
- Latency: forwarding 0 cycles (combinational). Stall asserts in the same cycle the hazard is present in decode.

Decomposition:
- GENERAL_DEFS package gets:
  - typedef fwd_sel_t (enum FWD_REGFILE=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3);
  - typedef hazard_entry_t (packed struct valid/dest/is_load);
  - existing ADDR_WIDTH and PC_REG_NUM reused.
- One combinational sub-module, operand_fwd_select: takes one operand address/use and the three entries; returns fwd_sel_t plus a load-use flag. It is instantiated twice.

Test Plan:
- Back-to-back ALU: cycle0 ADD r3 (writes r3), cycle1 SUB reads r3 as op1 -> fwd_sel_1_o=1, stall_o=0; cycle2 reader -> 2; cycle3 -> 3; cycle4 -> 0.
- Load-use: LDR r2, next instr reads r2 as op2 -> stall_o=1 one cycle; EX gets bubble; following cycle fwd_sel_2_o=2, stall_o=0.
- Priority: r5 written in WB and in EX (different instrs), reader of r5 -> fwd_sel=1. Reader of r15 with r15 in EX -> fwd_sel=0.
- Flush: LDR r1 in EX, decode reads r1, flush_i=1 -> stall_o=0; next cycle EX.valid=0.
- Hold: ADD r4 in EX, hold_i=1 for 3 cycles, reader of r4 -> fwd_sel stays 1 all 3 cycles; after release, advances to 2.
- Reset mid-stream: entries for r1/r2/r3 in flight, reset_i=1 -> next cycle all fwd_sel=0, stall_o=0 for readers of r1-r3.
